// File: rtl/myo_spi_slave.sv
// SPI mode-0 slave endpoint: oversamples SCK/MOSI/SS_N in the system clock domain, receives
// MSB-first words on MOSI and shifts a valid/ready-supplied word out on MISO.
module myo_spi_slave #(
   parameter int unsigned           WORD_WIDTH  = 16,
   parameter int unsigned           SYNC_STAGES = 2,
   parameter logic [WORD_WIDTH-1:0] IDLE_WORD   = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  sck,
   input  logic                  mosi,
   input  logic                  ss_n,
   output logic                  miso,
   output logic                  miso_oe,
   output logic [WORD_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic [WORD_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  frame_active,
   output logic [7:0]            word_count,
   output logic                  underrun_err,
   output logic                  frame_err,
   input  logic                  err_clear
);

   localparam int unsigned CW = $clog2(WORD_WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WORD_WIDTH - 1);

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ss_sync;
   logic                   sck_prev, ss_prev;
   logic                   sck_s, mosi_s, ss_s;
   logic                   sck_rise, sck_fall, ss_rise, ss_fall;

   logic [WORD_WIDTH-1:0]  shift_in, shift_out, shift_in_nxt;
   logic [CW-1:0]          bit_cnt;

   logic                   load, frame_start, sample, word_done, shift_en, frame_abort;

   // Synchroniser chains reset low, so a reset taken while ss_n is held low cannot
   // manufacture a falling edge: the master must deselect and reselect to start a frame.
   always_ff @(posedge clock) begin
      if (reset) begin
         sck_sync  <= '0;
         mosi_sync <= '0;
         ss_sync   <= '0;
         sck_prev  <= 1'b0;
         ss_prev   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
         sck_prev  <= sck_sync[SYNC_STAGES-1];
         ss_prev   <= ss_sync[SYNC_STAGES-1];
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign ss_s     = ss_sync[SYNC_STAGES-1];
   assign sck_rise =  sck_s & ~sck_prev;
   assign sck_fall = ~sck_s &  sck_prev;
   assign ss_rise  =  ss_s  & ~ss_prev;
   assign ss_fall  = ~ss_s  &  ss_prev;

   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path infers a latch.
      state_nxt   = state;
      load        = 1'b0;
      frame_start = 1'b0;
      sample      = 1'b0;
      word_done   = 1'b0;
      shift_en    = 1'b0;
      frame_abort = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ss_fall) begin
               state_nxt   = ST_ACTIVE;
               frame_start = 1'b1;
               load        = 1'b1;
            end
         end
         ST_ACTIVE: begin
            // A select edge masks any SCK edge seen in the same cycle.
            if (ss_rise) begin
               state_nxt   = ST_IDLE;
               frame_abort = (bit_cnt != '0);
            end else if (sck_rise) begin
               sample = 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  word_done = 1'b1;
                  load      = 1'b1;
               end
            end else if (sck_fall && bit_cnt != '0) begin
               shift_en = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign shift_in_nxt = {shift_in[WORD_WIDTH-2:0], mosi_s};
   assign tx_ready     = load & tx_valid;
   assign frame_active = (state == ST_ACTIVE);
   assign miso_oe      = frame_active;

   always_ff @(posedge clock) begin
      if (reset) begin
         shift_in     <= '0;
         shift_out    <= '0;
         bit_cnt      <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         word_count   <= '0;
         miso         <= 1'b0;
         underrun_err <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         rx_valid <= word_done;
         if (word_done) rx_data <= shift_in_nxt;
         if (sample)    shift_in <= shift_in_nxt;

         if (frame_start)  bit_cnt <= '0;
         else if (sample)  bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;

         if (frame_start)                            word_count <= '0;
         else if (word_done && word_count != 8'hFF)  word_count <= word_count + 8'd1;

         if (load)          shift_out <= tx_valid ? tx_data : IDLE_WORD;
         else if (shift_en) shift_out <= {shift_out[WORD_WIDTH-2:0], 1'b0};

         miso <= frame_active & shift_out[WORD_WIDTH-1];

         // Sticky flags: a set in the same cycle as err_clear takes priority.
         if (load && !tx_valid) underrun_err <= 1'b1;
         else if (err_clear)    underrun_err <= 1'b0;

         if (frame_abort)       frame_err <= 1'b1;
         else if (err_clear)    frame_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_myo_spi_slave.sv
// Directed bench for myo_spi_slave: a mode-0 SPI master model plus a tx-word producer,
// all driven from one process stepping on the falling system clock edge.
module tb_myo_spi_slave;

   logic        clock = 1'b0;
   logic        reset, sck, mosi, ss_n, err_clear, tx_valid;
   logic [15:0] tx_data;
   logic        miso, miso_oe, rx_valid, tx_ready, frame_active, underrun_err, frame_err;
   logic [15:0] rx_data;
   logic [7:0]  word_count;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          rx_cnt, ready_cnt;
   logic [15:0] rx_last;
   logic [15:0] tx_q[$];
   bit          pop_pending;

   myo_spi_slave #(.WORD_WIDTH(16), .SYNC_STAGES(2), .IDLE_WORD(16'h0000)) dut (
      .clock(clock), .reset(reset), .sck(sck), .mosi(mosi), .ss_n(ss_n),
      .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .frame_active(frame_active), .word_count(word_count),
      .underrun_err(underrun_err), .frame_err(frame_err), .err_clear(err_clear)
   );

   always #5 clock = ~clock;

   // One system clock step; observes strobes and services the tx producer queue.
   // A word seen consumed is popped one step later, after the load edge has passed.
   task automatic tick();
      @(negedge clock);
      if (rx_valid) begin
         rx_cnt++;
         rx_last = rx_data;
      end
      if (pop_pending) begin
         void'(tx_q.pop_front());
         pop_pending = 1'b0;
      end
      if (tx_ready) begin
         ready_cnt++;
         pop_pending = 1'b1;
      end
      tx_valid = (tx_q.size() != 0);
      tx_data  = tx_valid ? tx_q[0] : 16'h0000;
   endtask

   task automatic wait_ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   // Mode 0: MOSI set while SCK low, both sides sample on the rising edge. Half period = 6 clocks.
   task automatic spi_word(input logic [15:0] mo, output logic [15:0] mi, input int nbits);
      logic [15:0] sh;
      sh = mo;
      mi = '0;
      for (int b = 0; b < nbits; b++) begin
         mosi = sh[15];
         sh   = {sh[14:0], 1'b0};
         wait_ticks(6);
         mi  = {mi[14:0], miso};
         sck = 1'b1;
         wait_ticks(6);
         sck = 1'b0;
      end
   endtask

   task automatic frame_begin();
      ss_n = 1'b0;
      wait_ticks(8);
   endtask

   task automatic frame_end();
      wait_ticks(6);
      ss_n = 1'b1;
      wait_ticks(8);
   endtask

   task automatic clear_errors();
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; sck = 1'b0; mosi = 1'b0; ss_n = 1'b1; err_clear = 1'b0;
      tx_valid = 1'b0; tx_data = '0; pop_pending = 1'b0;
      wait_ticks(4);
      reset = 1'b0;
      wait_ticks(6);
      n_cmp++;
      if ({miso, miso_oe, rx_valid, tx_ready, frame_active, underrun_err, frame_err} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 0000000",
                  {miso, miso_oe, rx_valid, tx_ready, frame_active, underrun_err, frame_err});
      end
      n_cmp++;
      if (rx_data !== 16'h0000) begin
         n_bad++; $display("FAIL reset_rx_data: got %h want 0000", rx_data);
      end
      n_cmp++;
      if (word_count !== 8'd0) begin
         n_bad++; $display("FAIL reset_word_count: got %0d want 0", word_count);
      end
   endtask

   task automatic test_single_word();
      logic [15:0] mi;
      tx_q.push_back(16'hA5C3);
      rx_cnt = 0; ready_cnt = 0;
      frame_begin();
      n_cmp++;
      if (miso_oe !== 1'b1) begin
         n_bad++; $display("FAIL single_miso_oe: got %b want 1", miso_oe);
      end
      spi_word(16'h1234, mi, 16);
      frame_end();
      n_cmp++;
      if (mi !== 16'hA5C3) begin n_bad++; $display("FAIL single_miso_word: got %h want a5c3", mi); end
      n_cmp++;
      if (rx_last !== 16'h1234) begin n_bad++; $display("FAIL single_rx_data: got %h want 1234", rx_last); end
      n_cmp++;
      if (rx_cnt !== 1) begin n_bad++; $display("FAIL single_rx_pulses: got %0d want 1", rx_cnt); end
      n_cmp++;
      if (word_count !== 8'd1) begin n_bad++; $display("FAIL single_word_count: got %0d want 1", word_count); end
      n_cmp++;
      if (ready_cnt !== 1) begin n_bad++; $display("FAIL single_tx_ready: got %0d want 1", ready_cnt); end
      n_cmp++;
      if ({miso, miso_oe, frame_active} !== 3'b000) begin
         n_bad++; $display("FAIL single_idle_outputs: got %b want 000", {miso, miso_oe, frame_active});
      end
      clear_errors();
   endtask

   task automatic test_multi_word();
      logic [15:0] mi;
      tx_q.push_back(16'h0001);
      tx_q.push_back(16'h0002);
      rx_cnt = 0; ready_cnt = 0;
      frame_begin();
      spi_word(16'h1111, mi, 16);
      n_cmp++;
      if (mi !== 16'h0001) begin n_bad++; $display("FAIL multi_miso_w0: got %h want 0001", mi); end
      n_cmp++;
      if (underrun_err !== 1'b0) begin n_bad++; $display("FAIL multi_underrun_w0: got %b want 0", underrun_err); end
      spi_word(16'h2222, mi, 16);
      n_cmp++;
      if (mi !== 16'h0002) begin n_bad++; $display("FAIL multi_miso_w1: got %h want 0002", mi); end
      n_cmp++;
      if (underrun_err !== 1'b1) begin n_bad++; $display("FAIL multi_underrun_w1: got %b want 1", underrun_err); end
      spi_word(16'h3333, mi, 16);
      n_cmp++;
      if (mi !== 16'h0000) begin n_bad++; $display("FAIL multi_miso_w2: got %h want 0000", mi); end
      frame_end();
      n_cmp++;
      if (word_count !== 8'd3) begin n_bad++; $display("FAIL multi_word_count: got %0d want 3", word_count); end
      n_cmp++;
      if (rx_last !== 16'h3333 || rx_cnt !== 3) begin
         n_bad++; $display("FAIL multi_rx: got %h/%0d want 3333/3", rx_last, rx_cnt);
      end
      n_cmp++;
      if (ready_cnt !== 2) begin n_bad++; $display("FAIL multi_tx_ready: got %0d want 2", ready_cnt); end
      clear_errors();
   endtask

   task automatic test_partial_frame();
      logic [15:0] mi;
      rx_cnt = 0;
      frame_begin();
      spi_word(16'hFE00, mi, 7);
      frame_end();
      n_cmp++;
      if (rx_cnt !== 0) begin n_bad++; $display("FAIL partial_rx_pulses: got %0d want 0", rx_cnt); end
      n_cmp++;
      if (frame_err !== 1'b1) begin n_bad++; $display("FAIL partial_frame_err: got %b want 1", frame_err); end
      frame_begin();
      spi_word(16'hBEEF, mi, 16);
      frame_end();
      n_cmp++;
      if (rx_last !== 16'hBEEF || rx_cnt !== 1) begin
         n_bad++; $display("FAIL partial_next_rx: got %h/%0d want beef/1", rx_last, rx_cnt);
      end
      n_cmp++;
      if (word_count !== 8'd1) begin n_bad++; $display("FAIL partial_next_count: got %0d want 1", word_count); end
      clear_errors();
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] mi;
      tx_q.push_back(16'hFFFF);
      tx_q.push_back(16'hFFFF);
      frame_begin();
      spi_word(16'h1111, mi, 16);
      spi_word(16'h2222, mi, 9);
      n_cmp++;
      if (word_count !== 8'd1) begin n_bad++; $display("FAIL midreset_pre_count: got %0d want 1", word_count); end
      reset = 1'b1;
      wait_ticks(2);
      n_cmp++;
      if ({miso, miso_oe, frame_active} !== 3'b000 || word_count !== 8'd0) begin
         n_bad++; $display("FAIL midreset_outputs: got %b/%0d want 000/0", {miso, miso_oe, frame_active}, word_count);
      end
      reset = 1'b0;
      wait_ticks(10);
      n_cmp++;
      if (frame_active !== 1'b0) begin
         n_bad++; $display("FAIL midreset_no_resume: got %b want 0", frame_active);
      end
      ss_n = 1'b1;
      wait_ticks(8);
      rx_cnt = 0;
      frame_begin();
      spi_word(16'h5A5A, mi, 16);
      frame_end();
      n_cmp++;
      if (rx_last !== 16'h5A5A || rx_cnt !== 1) begin
         n_bad++; $display("FAIL midreset_next_rx: got %h/%0d want 5a5a/1", rx_last, rx_cnt);
      end
      clear_errors();
   endtask

   task automatic test_back_to_back();
      logic [15:0] mi;
      rx_cnt = 0;
      frame_begin();
      spi_word(16'hC0DE, mi, 16);
      n_cmp++;
      if (rx_last !== 16'hC0DE) begin n_bad++; $display("FAIL b2b_rx_a0: got %h want c0de", rx_last); end
      spi_word(16'h0F0F, mi, 16);
      n_cmp++;
      if (rx_last !== 16'h0F0F) begin n_bad++; $display("FAIL b2b_rx_a1: got %h want 0f0f", rx_last); end
      wait_ticks(6);
      ss_n = 1'b1;
      wait_ticks(24);
      n_cmp++;
      if (word_count !== 8'd2) begin n_bad++; $display("FAIL b2b_count_a: got %0d want 2", word_count); end
      frame_begin();
      n_cmp++;
      if (word_count !== 8'd0) begin n_bad++; $display("FAIL b2b_count_restart: got %0d want 0", word_count); end
      spi_word(16'h7E81, mi, 16);
      frame_end();
      n_cmp++;
      if (rx_last !== 16'h7E81 || rx_cnt !== 3 || word_count !== 8'd1) begin
         n_bad++; $display("FAIL b2b_frame_b: got %h/%0d/%0d want 7e81/3/1", rx_last, rx_cnt, word_count);
      end
      clear_errors();
   endtask

   task automatic test_err_clear();
      logic [15:0] mi;
      n_cmp++;
      if ({underrun_err, frame_err} !== 2'b00) begin
         n_bad++; $display("FAIL errclr_pre: got %b want 00", {underrun_err, frame_err});
      end
      // Empty tx queue: the frame-start load lands on the third clock edge after ss_n falls.
      ss_n = 1'b0;
      wait_ticks(2);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      tick();
      n_cmp++;
      if (underrun_err !== 1'b1) begin
         n_bad++; $display("FAIL errclr_set_wins: got %b want 1", underrun_err);
      end
      wait_ticks(4);
      spi_word(16'hAAAA, mi, 3);
      frame_end();
      n_cmp++;
      if (frame_err !== 1'b1) begin n_bad++; $display("FAIL errclr_frame_err_set: got %b want 1", frame_err); end
      clear_errors();
      n_cmp++;
      if ({underrun_err, frame_err} !== 2'b00) begin
         n_bad++; $display("FAIL errclr_alone: got %b want 00", {underrun_err, frame_err});
      end
   endtask

   initial begin
      rx_cnt = 0; ready_cnt = 0; rx_last = '0;
      test_reset();
      test_single_word();
      test_multi_word();
      test_partial_frame();
      test_reset_mid_frame();
      test_back_to_back();
      test_err_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
